// File: rtl/regfile_access_arbiter_pkg.sv
// Shared constants and state encoding for the register file access arbiter.
package regfile_access_arbiter_pkg;

  localparam int RV_DATA_WIDTH            = 32;
  localparam int RV_REG_ADDR_WIDTH        = 5;
  localparam int ARB_HALT_TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_HALT_WAIT = 3'd1,
    ARB_ACCESS    = 3'd2,
    ARB_RESP      = 3'd3,
    ARB_ABORT     = 3'd4,
    ARB_RELEASE   = 3'd5
  } arb_state_e;

endpackage

// File: rtl/regfile_access_arbiter_rr2.sv
// Two-input round-robin picker. On a tie the requester that was not granted
// last wins; last_grant only moves when the caller commits a grant.
module regfile_access_arbiter_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_q;
  logic last_d;

  // Pick a winner from the current request vector
  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt_idx = ~last_q;
    end else begin
      gnt_idx = req[1];
    end
  end

  // Remember the committed grant for the next tie
  always_comb begin
    last_d = last_q;
    if (update && gnt_valid) begin
      last_d = gnt_idx;
    end
  end

  // last_grant starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares the register file debug port between two requesters. The core is
// halted before any access; back-to-back requests share one halt window.
module regfile_access_arbiter
  import regfile_access_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = RV_DATA_WIDTH,
  parameter int ADDR_WIDTH   = RV_REG_ADDR_WIDTH,
  parameter int HALT_TIMEOUT = ARB_HALT_TIMEOUT_DEFAULT,
  parameter int TO_CNT_W     = $clog2(HALT_TIMEOUT + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_done,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  cpu_stop,
  input  logic                  cpu_halted,
  output logic [ADDR_WIDTH-1:0] regfile_addr,
  output logic                  regfile_write_enable,
  output logic [DATA_WIDTH-1:0] regfile_write_data,
  input  logic [DATA_WIDTH-1:0] regfile_read_data
);

  arb_state_e            state_q, state_d;
  logic [TO_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [1:0]            req;
  logic [1:0]            gnt_mask;
  logic [1:0]            arb_req;
  logic                  arb_valid;
  logic                  arb_idx;
  logic                  arb_update;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign req       = {m1_req, m0_req};
  assign gnt_mask  = gnt_q ? 2'b10 : 2'b01;
  // The requester just served is not eligible for the chained slot
  assign arb_req   = (state_q == ARB_RESP) ? (req & ~gnt_mask) : req;
  assign sel_we    = gnt_q ? m1_we : m0_we;
  assign sel_wdata = gnt_q ? m1_wdata : m0_wdata;

  regfile_access_arbiter_rr2 u_rr (
    .clk       (CLK),
    .rst       (RST),
    .req       (arb_req),
    .update    (arb_update),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // Next-state logic: halt handshake, timeout, grant and chaining
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    arb_update = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          state_d = ARB_HALT_WAIT;
          cnt_d   = '0;
        end
      end
      ARB_HALT_WAIT: begin
        if (!(|req)) begin
          state_d = ARB_RELEASE;
        end else if (cpu_halted) begin
          state_d    = ARB_ACCESS;
          arb_update = 1'b1;
          gnt_d      = arb_idx;
          addr_d     = arb_idx ? m1_addr : m0_addr;
        end else if (cnt_q == TO_CNT_W'(HALT_TIMEOUT - 1)) begin
          state_d = ARB_ABORT;
        end else begin
          cnt_d = cnt_q + TO_CNT_W'(1);
        end
      end
      ARB_ACCESS: begin
        rdata_d = sel_we ? '0 : regfile_read_data;
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (arb_valid) begin
          state_d    = ARB_ACCESS;
          arb_update = 1'b1;
          gnt_d      = arb_idx;
          addr_d     = arb_idx ? m1_addr : m0_addr;
        end else begin
          state_d = ARB_RELEASE;
        end
      end
      ARB_ABORT: begin
        state_d = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        if (!cpu_halted) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and captured access registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decoded from the current state; all quiet in IDLE and RELEASE
  always_comb begin
    m0_done              = 1'b0;
    m0_err               = 1'b0;
    m0_rdata             = '0;
    m1_done              = 1'b0;
    m1_err               = 1'b0;
    m1_rdata             = '0;
    cpu_stop             = (state_q == ARB_HALT_WAIT) || (state_q == ARB_ACCESS) ||
                           (state_q == ARB_RESP);
    regfile_addr         = addr_q;
    regfile_write_enable = 1'b0;
    regfile_write_data   = '0;
    case (state_q)
      ARB_ACCESS: begin
        regfile_write_enable = sel_we && (addr_q != '0);
        regfile_write_data   = sel_wdata;
      end
      ARB_RESP: begin
        if (gnt_q) begin
          m1_done  = 1'b1;
          m1_rdata = rdata_q;
        end else begin
          m0_done  = 1'b1;
          m0_rdata = rdata_q;
        end
      end
      ARB_ABORT: begin
        m0_done = m0_req;
        m0_err  = m0_req;
        m1_done = m1_req;
        m1_err  = m1_req;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: table of transactions with a scoreboard
// of expected completions, plus timeout, withdrawal and mid-access reset.
module tb_regfile_access_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 64;

  logic          CLK = 1'b0;
  logic          RST;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_done, m0_err, m1_done, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          cpu_stop;
  logic          cpu_halted = 1'b0;
  logic [AW-1:0] regfile_addr;
  logic          regfile_write_enable;
  logic [DW-1:0] regfile_write_data, regfile_read_data;

  logic [DW-1:0] rf [32] = '{default: '0};
  logic [DW-1:0] shadow [32];
  logic          stop_d1 = 1'b0;
  int            core_mode = 1;

  logic [106:0]  outs;
  assign outs = {m0_done, m0_err, m0_rdata, m1_done, m1_err, m1_rdata, cpu_stop,
                 regfile_addr, regfile_write_enable, regfile_write_data};

  regfile_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HALT_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .cpu_stop(cpu_stop), .cpu_halted(cpu_halted),
    .regfile_addr(regfile_addr), .regfile_write_enable(regfile_write_enable),
    .regfile_write_data(regfile_write_data), .regfile_read_data(regfile_read_data)
  );

  always #5 CLK = ~CLK;

  // Register file: combinational read, write on the rising edge
  assign regfile_read_data = rf[regfile_addr];
  always @(posedge CLK) begin
    if (regfile_write_enable) rf[regfile_addr] <= regfile_write_data;
  end

  // Core: acknowledges cpu_stop two cycles later (mode 1) or never (mode 0)
  always @(posedge CLK) begin
    stop_d1    <= cpu_stop;
    cpu_halted <= (core_mode == 1) ? stop_d1 : 1'b0;
  end

  typedef struct packed {
    logic          who;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic          r0;
    logic          we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1;
    logic          we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          first;
    int            exp_we;
  } vec_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   we_pulses = 0;
  int   stop_rises = 0;
  logic prev_stop = 1'b0;
  logic done_stop = 1'b0;
  vec_t vt [9];
  vec_t vp [2];

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_done(input logic who, input logic err, input logic [DW-1:0] rd);
    exp_t e;
    tests++;
    if (sbq.size() == 0) begin
      fails++;
      $display("FAIL unexpected_done m%0d: got err=%0b rdata=%h, expected no done", who, err, rd);
    end else begin
      e = sbq.pop_front();
      if (e.who !== who || e.err !== err || e.rdata !== rd) begin
        fails++;
        $display("FAIL done: got m%0d err=%0b rdata=%h, expected m%0d err=%0b rdata=%h",
                 who, err, rd, e.who, e.err, e.rdata);
      end
    end
  endtask

  // Advance one cycle and observe the DUT on the falling edge
  task automatic tick();
    @(negedge CLK);
    if (regfile_write_enable) we_pulses++;
    if (cpu_stop && !prev_stop) stop_rises++;
    prev_stop = cpu_stop;
    if (m0_done && m1_done) check_int("dual_done_only_on_abort", int'(m0_err && m1_err), 1);
    if (m0_done || m1_done) done_stop = cpu_stop;
    if (m0_done) begin check_done(1'b0, m0_err, m0_rdata); m0_req = 1'b0; end
    if (m1_done) begin check_done(1'b1, m1_err, m1_rdata); m1_req = 1'b0; end
  endtask

  task automatic predict(input logic who, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    exp_t e;
    e.who = who;
    e.err = 1'b0;
    e.rdata = '0;
    if (we) begin
      if (a != '0) shadow[a] = d;
    end else begin
      e.rdata = shadow[a];
    end
    sbq.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cpu_stop || cpu_halted) && n < 50) begin tick(); n++; end
    tick();
    check_int("released", int'(cpu_stop || cpu_halted), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0;
    prev_stop = cpu_stop;
    stop_rises = 0;
    we_pulses = 0;
    if (v.first == 1'b0) begin
      if (v.r0) predict(1'b0, v.we0, v.a0, v.d0);
      if (v.r1) predict(1'b1, v.we1, v.a1, v.d1);
    end else begin
      if (v.r1) predict(1'b1, v.we1, v.a1, v.d1);
      if (v.r0) predict(1'b0, v.we0, v.a0, v.d0);
    end
    m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
    m0_req = v.r0; m1_req = v.r1;
    while ((m0_req || m1_req) && n < 100) begin tick(); n++; end
    if (m0_req || m1_req) begin
      tests++; fails++;
      $display("FAIL done_wait: got no done within %0d cycles, expected done", n);
      m0_req = 1'b0; m1_req = 1'b0;
      sbq.delete();
    end
    wait_idle();
    check_int("write_pulses", we_pulses, v.exp_we);
    check_int("halt_windows", stop_rises, 1);
    check_int("scoreboard_empty", sbq.size(), 0);
  endtask

  initial begin
    int n;
    logic [AW-1:0] addr_before;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    //        r0  we0  a0    d0             r1  we1  a1    d1             first exp_we
    vt[0] = '{1'b1, 1'b1, 5'd1, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1};
    vt[1] = '{1'b1, 1'b0, 5'd1, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 0};
    vt[2] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd1, 32'h0,        1'b1, 0};
    vt[3] = '{1'b1, 1'b0, 5'd1, 32'h0,        1'b1, 1'b1, 5'd2, 32'h12345678, 1'b0, 1};
    vt[4] = '{1'b1, 1'b1, 5'd3, 32'h0000A5A5, 1'b1, 1'b0, 5'd2, 32'h0,        1'b0, 1};
    vt[5] = '{1'b1, 1'b0, 5'd3, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 0};
    vt[6] = '{1'b1, 1'b0, 5'd2, 32'h0,        1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 1'b1, 1};
    vt[7] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 0};
    vt[8] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 0};
    vp[0] = '{1'b1, 1'b0, 5'd2, 32'h0,        1'b1, 1'b0, 5'd4, 32'h0,        1'b0, 0};
    vp[1] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd3, 32'h0,        1'b1, 0};

    RST = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    tick(); tick();
    check_vec("reset_outputs", 128'(outs), 128'd0);
    RST = 1'b0;
    tick(); tick();
    check_vec("idle_outputs", 128'(outs), 128'd0);

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    // Halt never acknowledged: the request is aborted with an error
    core_mode = 0;
    tick(); tick();
    addr_before = regfile_addr;
    we_pulses = 0;
    begin
      exp_t e;
      e.who = 1'b0; e.err = 1'b1; e.rdata = '0;
      sbq.push_back(e);
    end
    m0_we = 1'b0; m0_addr = 5'd1; m0_req = 1'b1;
    n = 0;
    while (m0_req && n < TO + 20) begin tick(); n++; end
    check_int("timeout_cycles", n, TO + 1);
    check_int("timeout_cpu_stop", int'(done_stop), 0);
    check_int("timeout_write_pulses", we_pulses, 0);
    check_vec("timeout_addr_held", 128'(regfile_addr), 128'(addr_before));
    m0_req = 1'b0;
    wait_idle();

    // Request withdrawn while waiting for halt: no completion
    m1_we = 1'b0; m1_addr = 5'd2; m1_req = 1'b1;
    tick(); tick(); tick();
    check_int("withdraw_stop_high", int'(cpu_stop), 1);
    m1_req = 1'b0;
    n = 0;
    while (cpu_stop && n < 10) begin tick(); n++; end
    tick(); tick();
    check_int("withdraw_stop_low", int'(cpu_stop), 0);
    check_int("withdraw_no_done", sbq.size(), 0);
    core_mode = 1;
    wait_idle();

    // Reset asserted in the middle of an access
    m0_we = 1'b1; m0_addr = 5'd4; m0_wdata = 32'h0BAD0BAD; m0_req = 1'b1;
    n = 0;
    while (!regfile_write_enable && n < 20) begin tick(); n++; end
    check_int("reached_access", int'(regfile_write_enable), 1);
    #1 RST = 1'b1;
    #1 check_vec("reset_async_outputs", 128'(outs), 128'd0);
    m0_req = 1'b0;
    tick(); tick();
    RST = 1'b0;
    wait_idle();
    check_int("reset_no_done", sbq.size(), 0);
    for (int i = 0; i < 2; i++) run_vec(vp[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
